// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main controller.
// Sequences a shared-memory datapath over FETCH..WB states.
module multicycle_control #(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              Opcode,
  input  logic                    mem_ready,
  output logic                    PCWrite,
  output logic                    PCWriteCond,
  output logic                    IorD,
  output logic                    MemRead,
  output logic                    MemWrite,
  output logic                    IRWrite,
  output logic                    MemtoReg,
  output logic                    RegDst,
  output logic                    RegWrite,
  output logic                    ALUSrcA,
  output logic [1:0]              ALUSrcB,
  output logic [2:0]              ALUOp,
  output logic [1:0]              PCSrc,
  output logic                    illegal_op,
  output logic                    retire,
  output logic [RETIRE_CNT_W-1:0] instr_count,
  output logic [3:0]              state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTYPE  = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IMMEX  = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  logic       is_r;
  logic       is_imm;
  logic       is_mem;
  logic       is_beq;
  logic       is_lw;
  logic       is_andi;
  logic [3:0] nxt;

  assign is_r    = (Opcode == OP_R);
  assign is_andi = (Opcode == OP_ANDI);
  assign is_imm  = (Opcode == OP_ADDI) | is_andi;
  assign is_lw   = (Opcode == OP_LW);
  assign is_mem  = is_lw | (Opcode == OP_SW);
  assign is_beq  = (Opcode == OP_BEQ);

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          is_r:    nxt = S_RTYPE;
          is_imm:  nxt = S_IMMEX;
          is_mem:  nxt = S_MEMADR;
          is_beq:  nxt = S_BRANCH;
          default: nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE:  nxt = S_ALUWB;
      S_IMMEX:  nxt = S_IMMWB;
      default:  nxt = S_FETCH;
    endcase
  end

  // Everything stays 0 while reset is low, even mid-instruction.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSrc       = 2'b00;
    illegal_op  = 1'b0;
    retire      = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~(is_r | is_imm | is_mem | is_beq);
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          retire   = mem_ready;
        end
        S_RTYPE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        S_ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSrc       = 2'b01;
          retire      = 1'b1;
        end
        S_IMMEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = is_andi ? 3'b100 : 3'b011;
        end
        S_IMMWB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (retire)
        instr_count <= instr_count + RETIRE_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed + random checks of the
// multi-cycle controller against a plan-based reference model.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       ill;
    logic       ret;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic        mem_ready = 1'b0;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUOp;
  logic        illegal_op, retire;
  logic [31:0] instr_count;
  logic [3:0]  state;

  logic        w_pcw, w_pcwc, w_iord, w_mrd, w_mwr;
  logic        w_irw, w_m2r, w_rdst, w_rw, w_asa;
  logic [1:0]  w_asb, w_pcs;
  logic [2:0]  w_aop;
  logic        w_ill, w_ret;
  logic [1:0]  w_cnt;
  logic [3:0]  w_state;

  int tests = 0;
  int fails = 0;

  int          m_state = 0;
  int          plan[$];
  logic [31:0] m_cnt = '0;
  logic [1:0]  m_cnt_s = '0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSrc(PCSrc),
    .illegal_op(illegal_op), .retire(retire),
    .instr_count(instr_count), .state(state)
  );

  multicycle_control #(.RETIRE_CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode),
    .mem_ready(mem_ready),
    .PCWrite(w_pcw), .PCWriteCond(w_pcwc),
    .IorD(w_iord), .MemRead(w_mrd), .MemWrite(w_mwr),
    .IRWrite(w_irw), .MemtoReg(w_m2r),
    .RegDst(w_rdst), .RegWrite(w_rw),
    .ALUSrcA(w_asa), .ALUSrcB(w_asb),
    .ALUOp(w_aop), .PCSrc(w_pcs),
    .illegal_op(w_ill), .retire(w_ret),
    .instr_count(w_cnt), .state(w_state)
  );

  function automatic ctl_t exp_ctl(int s, logic [5:0] op,
                                   logic mr, logic rst);
    ctl_t c = '0;
    if (!rst) return c;
    case (s)
      0: begin c.mrd = 1; c.asb = 2'b01; c.irw = mr; c.pcw = mr; end
      1: begin
        c.asb = 2'b11;
        c.ill = !(op inside {OP_R, OP_ADDI, OP_ANDI,
                             OP_LW, OP_SW, OP_BEQ});
      end
      2: begin c.asa = 1; c.asb = 2'b10; end
      3: begin c.mrd = 1; c.iord = 1; end
      4: begin c.m2r = 1; c.rw = 1; c.ret = 1; end
      5: begin c.mwr = 1; c.iord = 1; c.ret = mr; end
      6: begin c.asa = 1; c.aop = 3'b010; end
      7: begin c.rdst = 1; c.rw = 1; c.ret = 1; end
      8: begin
        c.asa = 1; c.aop = 3'b001; c.pcwc = 1;
        c.pcs = 2'b01; c.ret = 1;
      end
      9: begin
        c.asa = 1; c.asb = 2'b10;
        c.aop = (op == OP_ANDI) ? 3'b100 : 3'b011;
      end
      10: begin c.rw = 1; c.ret = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Compare on each falling edge, then advance the model
  // with the inputs that the next rising edge will see.
  initial begin
    ctl_t e, a, aw;
    forever begin
      @(negedge clk);
      e  = exp_ctl(m_state, Opcode, mem_ready, rst_n);
      a  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
            IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, illegal_op, retire};
      aw = {w_pcw, w_pcwc, w_iord, w_mrd, w_mwr,
            w_irw, w_m2r, w_rdst, w_rw, w_asa,
            w_asb, w_aop, w_pcs, w_ill, w_ret};
      chk("ctl", 64'(a), 64'(e));
      chk("state", 64'(state), 64'(m_state));
      chk("count", 64'(instr_count), 64'(m_cnt));
      chk("ctl_w", 64'(aw), 64'(e));
      chk("count_w", 64'(w_cnt), 64'(m_cnt_s));
      chk("rd_wr_excl", 64'(MemRead & MemWrite), 64'd0);
      if (!rst_n) begin
        m_state = 0; m_cnt = '0; m_cnt_s = '0;
        plan.delete();
      end else begin
        if (e.ret) begin m_cnt++; m_cnt_s++; end
        if ((m_state == 0 || m_state == 3 || m_state == 5)
            && !mem_ready) begin
          m_state = m_state;
        end else if (m_state == 0) begin
          m_state = 1;
        end else begin
          if (m_state == 1) begin
            case (Opcode)
              OP_R:    plan = '{6, 7};
              OP_ADDI: plan = '{9, 10};
              OP_ANDI: plan = '{9, 10};
              OP_LW:   plan = '{2, 3, 4};
              OP_SW:   plan = '{2, 5};
              OP_BEQ:  plan = '{8};
              default: plan.delete();
            endcase
          end
          if (plan.size() > 0) m_state = plan.pop_front();
          else m_state = 0;
        end
      end
    end
  end

  task automatic cyc(logic [5:0] op, logic mr, logic rst);
    @(posedge clk);
    #1;
    Opcode = op;
    mem_ready = mr;
    rst_n = rst;
    @(negedge clk);
    #1;
  endtask

  logic [5:0] legal [6] = '{OP_R, OP_ADDI, OP_ANDI,
                            OP_LW, OP_SW, OP_BEQ};
  logic [5:0] seq_op [3] = '{OP_R, OP_ADDI, OP_ANDI};
  logic [2:0] seq_aop [3] = '{3'b010, 3'b011, 3'b100};
  int         seq_ex [3] = '{6, 9, 9};
  int         seq_wb [3] = '{7, 10, 10};

  initial begin
    cyc(OP_LW, 0, 0);
    cyc(OP_LW, 0, 0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cnt", 64'(instr_count), 64'd0);
    chk("rst_mrd", 64'(MemRead), 64'd0);

    cyc(OP_LW, 1, 1);
    chk("lw_c1_state", 64'(state), 64'd0);
    chk("lw_c1_mrd", 64'(MemRead), 64'd1);
    cyc(OP_LW, 1, 1); chk("lw_c2", 64'(state), 64'd1);
    cyc(OP_LW, 1, 1); chk("lw_c3", 64'(state), 64'd2);
    cyc(OP_LW, 1, 1); chk("lw_c4", 64'(state), 64'd3);
    chk("lw_c4_rw", 64'(RegWrite), 64'd0);
    cyc(OP_LW, 1, 1); chk("lw_c5", 64'(state), 64'd4);
    chk("lw_c5_rw", 64'({RegWrite, MemtoReg, retire}), 64'h7);
    cyc(OP_LW, 1, 1); chk("lw_end", 64'(state), 64'd0);
    chk("lw_cnt", 64'(instr_count), 64'd1);

    cyc(OP_SW, 1, 1); chk("sw_d", 64'(state), 64'd1);
    cyc(OP_SW, 1, 1); chk("sw_ma", 64'(state), 64'd2);
    for (int i = 0; i < 3; i++) begin
      cyc(OP_SW, 0, 1);
      chk("sw_wait", 64'({state, MemWrite, retire}),
          64'({4'd5, 1'b1, 1'b0}));
    end
    cyc(OP_SW, 1, 1);
    chk("sw_done", 64'({state, MemWrite, retire}),
        64'({4'd5, 1'b1, 1'b1}));
    cyc(OP_SW, 1, 1); chk("sw_end", 64'(state), 64'd0);
    chk("sw_cnt", 64'(instr_count), 64'd2);

    for (int k = 0; k < 3; k++) begin
      cyc(seq_op[k], 1, 1);
      chk("seq_d", 64'(state), 64'd1);
      cyc(seq_op[k], 1, 1);
      chk("seq_ex", 64'(state), 64'(seq_ex[k]));
      chk("seq_aop", 64'(ALUOp), 64'(seq_aop[k]));
      cyc(seq_op[k], 1, 1);
      chk("seq_wb", 64'(state), 64'(seq_wb[k]));
      chk("seq_rdst", 64'(RegDst), 64'(k == 0));
      cyc(seq_op[k], 1, 1);
      chk("seq_f", 64'(state), 64'd0);
    end
    chk("seq_cnt", 64'(instr_count), 64'd5);

    cyc(OP_BEQ, 1, 1); chk("beq_d", 64'(state), 64'd1);
    cyc(OP_BEQ, 1, 1);
    chk("beq_br", 64'({PCWriteCond, PCSrc, ALUOp}),
        64'({1'b1, 2'b01, 3'b001}));
    cyc(OP_BEQ, 1, 1); chk("beq_end", 64'(state), 64'd0);
    chk("beq_cnt", 64'(instr_count), 64'd6);

    cyc(OP_J, 1, 1);
    chk("ill_d", 64'({illegal_op, RegWrite, MemWrite}), 64'h4);
    cyc(OP_J, 1, 1);
    chk("ill_end", 64'({state, illegal_op}), 64'd0);
    chk("ill_cnt", 64'(instr_count), 64'd6);

    cyc(OP_LW, 1, 1);
    cyc(OP_LW, 1, 1);
    cyc(OP_LW, 0, 1); chk("abort_rd", 64'(state), 64'd3);
    cyc(OP_LW, 0, 0);
    chk("abort_ctl", 64'({MemRead, IorD, RegWrite, retire}), 64'd0);
    cyc(OP_LW, 0, 0);
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_cnt", 64'(instr_count), 64'd0);

    cyc(OP_BEQ, 1, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(OP_BEQ, 1, 1); cyc(OP_BEQ, 1, 1); cyc(OP_BEQ, 1, 1);
    end
    chk("wrap_full", 64'(w_cnt), 64'd3);
    cyc(OP_BEQ, 1, 1); cyc(OP_BEQ, 1, 1); cyc(OP_BEQ, 1, 1);
    chk("wrap_zero", 64'(w_cnt), 64'd0);
    chk("wrap_main", 64'(instr_count), 64'd4);

    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      #1;
      if (m_state == 0) begin
        if ($urandom_range(0, 7) < 6)
          Opcode = legal[$urandom_range(0, 5)];
        else
          Opcode = 6'($urandom_range(0, 63));
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
